// File: rtl/blend_pkg.sv
// Shared types for the blend sequencer: controller states and mixing pattern codes.
package blend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_RUN      = 3'd2,
        ST_PULSE_LO = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // Mode[3:2]; the reserved code behaves like constant speed
    typedef enum logic [1:0] {
        PAT_CONST = 2'b00,
        PAT_PULSE = 2'b01,
        PAT_RAMP  = 2'b10,
        PAT_RSVD  = 2'b11
    } pattern_t;

    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE) && (s != ST_FAULT);
    endfunction

endpackage

// File: rtl/blend_tick_gen.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
module blend_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count, wrapping at TICK_DIV-1
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/blend_sequencer.sv
// Blender motor sequencer: constant, pulse and ramp run patterns with a lid
// interlock, abort, and a tick-based run timer.
module blend_sequencer
    import blend_pkg::*;
#(
    parameter int SPEED_W   = 2,
    parameter int TIMER_W   = 8,
    parameter int TICK_DIV  = 10,
    parameter int PULSE_ON  = 4,
    parameter int PULSE_OFF = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Mode,
    input  logic               start,
    input  logic               stop,
    input  logic               lid_closed,
    input  logic [TIMER_W-1:0] duration,
    output logic [SPEED_W-1:0] out,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    localparam int PH_MAX = (PULSE_ON > PULSE_OFF) ? PULSE_ON : PULSE_OFF;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic [TIMER_W-1:0] remaining_q, remaining_d;
    logic [3:0]         mode_q, mode_d;
    logic [PH_W-1:0]    phase_q, phase_d;

    logic               tick_s;
    logic [SPEED_W-1:0] tgt_s;
    logic [SPEED_W-1:0] tgt_in_s;
    pattern_t           pat_s;

    blend_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign tgt_s    = SPEED_W'(mode_q[1:0]);
    assign tgt_in_s = SPEED_W'(Mode[1:0]);
    assign pat_s    = pattern_t'(mode_q[3:2]);

    // next-state and output computation; priority stop > lid open > expiry > step
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        phase_d     = phase_q;

        case (state_q)
            ST_IDLE: begin
                out_d = {SPEED_W{1'b0}};
                if (start && !stop && lid_closed) begin
                    mode_d      = Mode;
                    remaining_d = duration;
                    phase_d     = {PH_W{1'b0}};
                    if ((duration == {TIMER_W{1'b0}}) || (Mode[1:0] == 2'b00)) begin
                        done_d = 1'b1;
                    end else begin
                        case (pattern_t'(Mode[3:2]))
                            PAT_RAMP: begin
                                state_d = ST_RAMP;
                                out_d   = SPEED_W'(1);
                            end
                            default: begin
                                state_d = ST_RUN;
                                out_d   = tgt_in_s;
                            end
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RAMP, ST_RUN, ST_PULSE_LO: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    out_d   = {SPEED_W{1'b0}};
                end else if (!lid_closed) begin
                    state_d = ST_FAULT;
                    out_d   = {SPEED_W{1'b0}};
                end else if (tick_s) begin
                    remaining_d = remaining_q - TIMER_W'(1);
                    if (remaining_q == TIMER_W'(1)) begin
                        state_d = ST_IDLE;
                        out_d   = {SPEED_W{1'b0}};
                        done_d  = 1'b1;
                    end else begin
                        case (state_q)
                            ST_RAMP: begin
                                // a target of 1 is already reached on entry
                                if (out_q >= tgt_s) begin
                                    state_d = ST_RUN;
                                end else begin
                                    out_d = out_q + SPEED_W'(1);
                                    if ((out_q + SPEED_W'(1)) == tgt_s) begin
                                        state_d = ST_RUN;
                                    end else begin
                                        state_d = ST_RAMP;
                                    end
                                end
                            end
                            ST_RUN: begin
                                if (pat_s == PAT_PULSE) begin
                                    if (phase_q == PH_W'(PULSE_ON - 1)) begin
                                        state_d = ST_PULSE_LO;
                                        out_d   = {SPEED_W{1'b0}};
                                        phase_d = {PH_W{1'b0}};
                                    end else begin
                                        phase_d = phase_q + PH_W'(1);
                                    end
                                end else begin
                                    out_d = tgt_s;
                                end
                            end
                            ST_PULSE_LO: begin
                                if (phase_q == PH_W'(PULSE_OFF - 1)) begin
                                    state_d = ST_RUN;
                                    out_d   = tgt_s;
                                    phase_d = {PH_W{1'b0}};
                                end else begin
                                    phase_d = phase_q + PH_W'(1);
                                end
                            end
                            default: begin
                                state_d = ST_IDLE;
                                out_d   = {SPEED_W{1'b0}};
                            end
                        endcase
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_FAULT: begin
                out_d = {SPEED_W{1'b0}};
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end

            default: begin
                state_d = ST_IDLE;
                out_d   = {SPEED_W{1'b0}};
            end
        endcase

        busy_d  = is_busy(state_d);
        fault_d = (state_d == ST_FAULT);
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_q       <= {SPEED_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            remaining_q <= {TIMER_W{1'b0}};
            mode_q      <= 4'b0000;
            phase_q     <= {PH_W{1'b0}};
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
        end
    end

    assign out   = out_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_blend_sequencer.sv
// Directed self-checking bench for blend_sequencer (TICK_DIV=2, PULSE_ON=2, PULSE_OFF=1).
module tb_blend_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] Mode;
    logic       start;
    logic       stop;
    logic       lid_closed;
    logic [7:0] duration;
    logic [1:0] out;
    logic       busy;
    logic       done;
    logic       fault;
    logic [4:0] obs;

    int checks = 0;
    int fails  = 0;

    blend_sequencer #(
        .SPEED_W   (2),
        .TIMER_W   (8),
        .TICK_DIV  (2),
        .PULSE_ON  (2),
        .PULSE_OFF (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Mode       (Mode),
        .start      (start),
        .stop       (stop),
        .lid_closed (lid_closed),
        .duration   (duration),
        .out        (out),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    assign obs = {out, busy, done, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // After this returns the tick counter is 0; the following cycle carries a tick.
    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        lid_closed = 1'b1;
        Mode = 4'b0000;
        duration = 8'd0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        if (obs !== 5'b00000) begin
            $display("FAIL reset_state: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
    endtask

    task automatic test_const();
        apply_reset();
        cycle();
        Mode = 4'b0011; duration = 8'd5; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (obs !== {2'd3, 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL const_run[%0d]: got %b want %b", i, obs, {2'd3, 1'b1, 1'b0, 1'b0}); fails++;
            end
            checks++;
            if (i == 2) begin
                start = 1'b1; Mode = 4'b0001; duration = 8'd1;
            end else begin
                start = 1'b0;
            end
            cycle();
        end
        if (obs !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL const_done: got %b want %b", obs, {2'd0, 1'b0, 1'b1, 1'b0}); fails++;
        end
        checks++;
        cycle();
        if (obs !== 5'b00000) begin
            $display("FAIL const_done_clear: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
    endtask

    task automatic test_ramp();
        logic [1:0] exp_out;
        apply_reset();
        cycle();
        Mode = 4'b1011; duration = 8'd8; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            exp_out = (i <= 2) ? 2'd1 : ((i <= 4) ? 2'd2 : 2'd3);
            if (obs !== {exp_out, 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL ramp_out[%0d]: got %b want %b", i, obs, {exp_out, 1'b1, 1'b0, 1'b0}); fails++;
            end
            checks++;
            cycle();
        end
        if (obs !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL ramp_done: got %b want %b", obs, {2'd0, 1'b0, 1'b1, 1'b0}); fails++;
        end
        checks++;
    endtask

    task automatic test_pulse();
        logic [1:0] pat [6];
        pat = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0};
        apply_reset();
        cycle();
        Mode = 4'b0110; duration = 8'd6; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (obs !== {pat[(i - 1) / 2], 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL pulse_out[%0d]: got %b want %b", i, obs, {pat[(i - 1) / 2], 1'b1, 1'b0, 1'b0}); fails++;
            end
            checks++;
            cycle();
        end
        if (obs !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL pulse_done: got %b want %b", obs, {2'd0, 1'b0, 1'b1, 1'b0}); fails++;
        end
        checks++;
    endtask

    task automatic test_fault();
        apply_reset();
        Mode = 4'b0011; duration = 8'd100; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        if (obs !== {2'd3, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL fault_pre_run: got %b want %b", obs, {2'd3, 1'b1, 1'b0, 1'b0}); fails++;
        end
        checks++;
        lid_closed = 1'b0;
        cycle();
        if (obs !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL fault_enter: got %b want %b", obs, {2'd0, 1'b0, 1'b0, 1'b1}); fails++;
        end
        checks++;
        lid_closed = 1'b1; start = 1'b1; duration = 8'd5;
        cycle();
        start = 1'b0;
        if (obs !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL fault_ignore_start: got %b want %b", obs, {2'd0, 1'b0, 1'b0, 1'b1}); fails++;
        end
        checks++;
        cycle();
        if (obs !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL fault_hold: got %b want %b", obs, {2'd0, 1'b0, 1'b0, 1'b1}); fails++;
        end
        checks++;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        if (obs !== 5'b00000) begin
            $display("FAIL fault_clear: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
        cycle();
        if (obs !== 5'b00000) begin
            $display("FAIL fault_idle_after: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
    endtask

    task automatic test_stop_and_zero();
        apply_reset();
        cycle();
        Mode = 4'b0001; duration = 8'd1; start = 1'b1;
        cycle();
        start = 1'b0;
        if (obs !== {2'd1, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL stopexp_run: got %b want %b", obs, {2'd1, 1'b1, 1'b0, 1'b0}); fails++;
        end
        checks++;
        cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        if (obs !== 5'b00000) begin
            $display("FAIL stop_beats_expiry: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
        cycle();
        if (obs !== 5'b00000) begin
            $display("FAIL stop_no_late_done: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
        Mode = 4'b0011; duration = 8'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        if (obs !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL zero_duration_done: got %b want %b", obs, {2'd0, 1'b0, 1'b1, 1'b0}); fails++;
        end
        checks++;
        cycle();
        if (obs !== 5'b00000) begin
            $display("FAIL zero_duration_clear: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
        Mode = 4'b0000; duration = 8'd5; start = 1'b1;
        cycle();
        start = 1'b0;
        if (obs !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL zero_target_done: got %b want %b", obs, {2'd0, 1'b0, 1'b1, 1'b0}); fails++;
        end
        checks++;
        lid_closed = 1'b0; Mode = 4'b0011; duration = 8'd5; start = 1'b1;
        cycle();
        if (obs !== 5'b00000) begin
            $display("FAIL start_lid_open: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
        lid_closed = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        if (obs !== 5'b00000) begin
            $display("FAIL start_with_stop: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_ramp();
        apply_reset();
        cycle();
        Mode = 4'b1011; duration = 8'd20; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        cycle();
        if (obs !== {2'd2, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL midramp_pre: got %b want %b", obs, {2'd2, 1'b1, 1'b0, 1'b0}); fails++;
        end
        checks++;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        if (obs !== 5'b00000) begin
            $display("FAIL midramp_reset: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
        cycle();
        if (obs !== 5'b00000) begin
            $display("FAIL midramp_after: got %b want %b", obs, 5'b00000); fails++;
        end
        checks++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        lid_closed = 1'b1;
        Mode = 4'b0000;
        duration = 8'd0;
        test_reset();
        test_const();
        test_ramp();
        test_pulse();
        test_fault();
        test_stop_and_zero();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
